// File: rtl/anticipator_port_arb_if.sv
// Purpose: bundles requester, response and anticipator-RAM read-port signals of the port arbiter.
// Latency: none (signal container only).
// Backpressure: req_ready is the per-requester grant; responses cannot be backpressured.
interface anticipator_port_arb_if #(
  parameter int NREQ = 8,
  parameter int AW   = 12,
  parameter int DW   = 2,
  parameter int TAGW = 4
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*TAGW-1:0] req_tag;
  logic [NREQ-1:0]      req_ready;
  logic                 stall;
  logic                 flush;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ*DW-1:0]   rsp_data;
  logic [NREQ*TAGW-1:0] rsp_tag;
  logic [AW-1:0]        ram_addr0;
  logic [AW-1:0]        ram_addr1;
  logic [AW-1:0]        ram_addr2;
  logic [AW-1:0]        ram_addr3;
  logic [DW-1:0]        ram_data0;
  logic [DW-1:0]        ram_data1;
  logic [DW-1:0]        ram_data2;
  logic [DW-1:0]        ram_data3;

  // Arbiter side
  modport slave (
    input  req_valid, req_addr, req_tag, stall, flush,
    input  ram_data0, ram_data1, ram_data2, ram_data3,
    output req_ready, rsp_valid, rsp_data, rsp_tag,
    output ram_addr0, ram_addr1, ram_addr2, ram_addr3
  );

  // Requester / RAM side
  modport master (
    output req_valid, req_addr, req_tag, stall, flush,
    output ram_data0, ram_data1, ram_data2, ram_data3,
    input  req_ready, rsp_valid, rsp_data, rsp_tag,
    input  ram_addr0, ram_addr1, ram_addr2, ram_addr3
  );
endinterface

// File: rtl/anticipator_port_arb.sv
// Purpose: round-robin share of the anticipator RAM's four read ports among NREQ requesters.
// Latency: response registered, rsp_valid exactly one cycle after acceptance.
// Backpressure: stall blocks all grants; responses have no backpressure, requesters must sink them.
module anticipator_port_arb #(
  parameter int NREQ = 8,
  parameter int AW   = 12,
  parameter int DW   = 2,
  parameter int TAGW = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  anticipator_port_arb_if.slave  bus
);
  localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NPORT = 4;

  logic [PW-1:0]        r_rr_ptr;
  logic [NREQ-1:0]      r_rsp_valid;
  logic [NREQ*DW-1:0]   r_rsp_data;
  logic [NREQ*TAGW-1:0] r_rsp_tag;

  logic [NREQ-1:0]  w_grant;
  logic [1:0]       w_req_slot [NREQ];
  logic [NPORT-1:0] w_slot_vld;
  logic [PW-1:0]    w_slot_idx [NPORT];
  logic [PW-1:0]    w_last;
  logic [2:0]       w_cnt;
  logic [PW:0]      w_sum;
  logic [PW-1:0]    w_idx;
  logic [PW:0]      w_last_p1;
  logic [PW-1:0]    w_ptr_nxt;
  logic [AW-1:0]    w_port_addr [NPORT];
  logic [DW-1:0]    w_port_data [NPORT];

  // Scan from rr_ptr with wrap; the first four valid requesters take slots 0..3 in scan order
  always_comb begin
    w_grant    = '0;
    w_slot_vld = '0;
    w_last     = r_rr_ptr;
    w_cnt      = '0;
    w_sum      = '0;
    w_idx      = '0;
    for (int i = 0; i < NREQ; i++) w_req_slot[i] = '0;
    for (int k = 0; k < NPORT; k++) w_slot_idx[k] = '0;
    if (!rst && !bus.stall) begin
      for (int off = 0; off < NREQ; off++) begin
        w_sum = {1'b0, r_rr_ptr} + (PW+1)'(off);
        if (w_sum >= (PW+1)'(NREQ)) w_sum = w_sum - (PW+1)'(NREQ);
        w_idx = w_sum[PW-1:0];
        if (bus.req_valid[w_idx] && (w_cnt < 3'd4)) begin
          w_grant[w_idx]           = 1'b1;
          w_slot_vld[w_cnt[1:0]]   = 1'b1;
          w_slot_idx[w_cnt[1:0]]   = w_idx;
          w_req_slot[w_idx]        = w_cnt[1:0];
          w_last                   = w_idx;
          w_cnt                    = w_cnt + 3'd1;
        end
      end
    end
  end

  // Slot address mux (idle slots park at address 0) and next pointer after the last grant
  always_comb begin
    for (int k = 0; k < NPORT; k++) begin
      w_port_addr[k] = w_slot_vld[k] ? bus.req_addr[w_slot_idx[k]*AW +: AW] : '0;
    end
    w_last_p1 = {1'b0, w_last} + (PW+1)'(1);
    w_ptr_nxt = (w_last_p1 >= (PW+1)'(NREQ)) ? '0 : w_last_p1[PW-1:0];
  end

  assign bus.ram_addr0  = w_port_addr[0];
  assign bus.ram_addr1  = w_port_addr[1];
  assign bus.ram_addr2  = w_port_addr[2];
  assign bus.ram_addr3  = w_port_addr[3];
  assign w_port_data[0] = bus.ram_data0;
  assign w_port_data[1] = bus.ram_data1;
  assign w_port_data[2] = bus.ram_data2;
  assign w_port_data[3] = bus.ram_data3;

  // Capture slot data and tags of granted requesters; advance the pointer past the last grant
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_tag   <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_grant[i]) begin
          r_rsp_data[i*DW +: DW]     <= w_port_data[w_req_slot[i]];
          r_rsp_tag[i*TAGW +: TAGW]  <= bus.req_tag[i*TAGW +: TAGW];
          r_rsp_valid[i]             <= ~bus.flush;
        end else begin
          r_rsp_valid[i]             <= 1'b0;
        end
      end
      if (|w_grant) r_rr_ptr <= w_ptr_nxt;
    end
  end

  assign bus.req_ready = w_grant;
  // A response registered just before reset must not surface during the reset cycle
  assign bus.rsp_valid = r_rsp_valid & {NREQ{~rst}};
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_tag   = r_rsp_tag;
endmodule

// File: tb/tb_anticipator_port_arb.sv
// Testbench for anticipator_port_arb: directed grant vectors, scoreboarded responses.
// Grants and RAM addresses are checked in the cycle they are driven.
// Responses are queued at issue and compared by an independent monitor.
module tb_anticipator_port_arb;
  localparam int NREQ = 8;
  localparam int AW   = 12;
  localparam int DW   = 2;
  localparam int TAGW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  anticipator_port_arb_if #(.NREQ(NREQ), .AW(AW), .DW(DW), .TAGW(TAGW)) bus ();

  anticipator_port_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .TAGW(TAGW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Anticipator RAM stand-in: combinational read, data = addr[1:0] ^ addr[7:6]
  function automatic logic [1:0] ram_f(input logic [11:0] a);
    return a[1:0] ^ a[7:6];
  endfunction

  assign bus.ram_data0 = ram_f(bus.ram_addr0);
  assign bus.ram_data1 = ram_f(bus.ram_addr1);
  assign bus.ram_data2 = ram_f(bus.ram_addr2);
  assign bus.ram_data3 = ram_f(bus.ram_addr3);

  typedef struct packed {
    logic [31:0] due;
    logic [7:0]  mask;
    logic [15:0] data;
    logic [31:0] tag;
  } exp_t;

  exp_t        q[$];
  int          cyc   = 0;
  int          nchk  = 0;
  int          npass = 0;
  logic [11:0] baddr [NREQ];
  logic [3:0]  btag  [NREQ];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  // One arbitration cycle: drive, check grant/addresses, queue the expected response
  task automatic step(input logic r, input logic [7:0] v, input logic s, input logic f,
                      input logic [7:0] er, input int s0, input int s1, input int s2, input int s3);
    int          sl [4];
    logic [11:0] pa [4];
    logic [11:0] ea;
    exp_t        e;
    @(posedge clk);
    #1;
    rst           = r;
    bus.req_valid = v;
    bus.stall     = s;
    bus.flush     = f;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_addr[i*AW +: AW]     = baddr[i];
      bus.req_tag[i*TAGW +: TAGW]  = btag[i];
    end
    @(negedge clk);
    chk("req_ready", 32'(bus.req_ready), 32'(er));
    sl = '{s0, s1, s2, s3};
    pa = '{bus.ram_addr0, bus.ram_addr1, bus.ram_addr2, bus.ram_addr3};
    for (int k = 0; k < 4; k++) begin
      ea = (sl[k] < 0) ? 12'h000 : baddr[sl[k]];
      chk($sformatf("ram_addr%0d", k), 32'(pa[k]), 32'(ea));
    end
    e      = '0;
    e.due  = 32'(cyc + 1);
    e.mask = f ? 8'h00 : er;
    for (int i = 0; i < NREQ; i++) begin
      e.data[i*DW +: DW]     = ram_f(baddr[i]);
      e.tag[i*TAGW +: TAGW]  = btag[i];
    end
    q.push_back(e);
  endtask

  // Response monitor: every cycle compare rsp_valid, and data/tag of expected responders
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && int'(q[0].due) < cyc) void'(q.pop_front());
      e = '0;
      if (q.size() > 0 && int'(q[0].due) == cyc) e = q.pop_front();
      if (rst) e.mask = 8'h00;
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(e.mask));
      for (int i = 0; i < NREQ; i++) begin
        if (e.mask[i]) begin
          chk($sformatf("rsp_data[%0d]", i), 32'(bus.rsp_data[i*DW +: DW]), 32'(e.data[i*DW +: DW]));
          chk($sformatf("rsp_tag[%0d]", i), 32'(bus.rsp_tag[i*TAGW +: TAGW]), 32'(e.tag[i*TAGW +: TAGW]));
        end
      end
    end
  end

  initial begin
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_tag   = '0;
    bus.stall     = 1'b0;
    bus.flush     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      baddr[i] = 12'(i);
      btag[i]  = 4'(i + 1);
    end

    // Reset with all requesters valid: no grants, ports parked
    step(1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, -1, -1, -1, -1);
    step(1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, -1, -1, -1, -1);
    chk("reset rsp_data", 32'(bus.rsp_data), 32'h0);
    chk("reset rsp_tag",  32'(bus.rsp_tag),  32'h0);

    // All valid: 0..3 then 4..7, pointer back to 0
    step(1'b0, 8'hFF, 1'b0, 1'b0, 8'h0F, 0, 1, 2, 3);
    step(1'b0, 8'hFF, 1'b0, 1'b0, 8'hF0, 4, 5, 6, 7);

    // Single requester 5 at 0x081 with tag A -> data 2'b11; pointer -> 6
    baddr[5] = 12'h081;
    btag[5]  = 4'hA;
    step(1'b0, 8'h20, 1'b0, 1'b0, 8'h20, 5, -1, -1, -1);

    // Single requester 2 at address 0, found after wrapping from 6; pointer -> 3
    baddr[2] = 12'h000;
    step(1'b0, 8'h04, 1'b0, 1'b0, 8'h04, 2, -1, -1, -1);
    baddr[2] = 12'h002;
    baddr[5] = 12'h005;
    btag[5]  = 4'h6;

    // Move pointer to 6, then 7,0,1,3,4 valid: 4 waits, then leads the next cycle
    step(1'b0, 8'h20, 1'b0, 1'b0, 8'h20, 5, -1, -1, -1);
    step(1'b0, 8'h9B, 1'b0, 1'b0, 8'h8B, 7, 0, 1, 3);
    step(1'b0, 8'h9B, 1'b0, 1'b0, 8'h93, 4, 7, 0, 1);

    // Stall three cycles at pointer 2, then resume from 2
    step(1'b0, 8'hFF, 1'b1, 1'b0, 8'h00, -1, -1, -1, -1);
    step(1'b0, 8'hFF, 1'b1, 1'b0, 8'h00, -1, -1, -1, -1);
    step(1'b0, 8'hFF, 1'b1, 1'b0, 8'h00, -1, -1, -1, -1);
    step(1'b0, 8'hFF, 1'b0, 1'b0, 8'h3C, 2, 3, 4, 5);
    step(1'b0, 8'h80, 1'b0, 1'b0, 8'h80, 7, -1, -1, -1);

    // Flush: grants 0..3 consumed silently; repeat delivers; stall+flush grants nothing
    step(1'b0, 8'hFF, 1'b0, 1'b1, 8'h0F, 0, 1, 2, 3);
    step(1'b0, 8'h0F, 1'b0, 1'b0, 8'h0F, 0, 1, 2, 3);
    step(1'b0, 8'hFF, 1'b1, 1'b1, 8'h00, -1, -1, -1, -1);

    // Reset right after a grant: response suppressed, arbitration restarts at 0
    step(1'b0, 8'h03, 1'b0, 1'b0, 8'h03, 0, 1, -1, -1);
    step(1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, -1, -1, -1, -1);
    step(1'b0, 8'hFF, 1'b0, 1'b0, 8'h0F, 0, 1, 2, 3);

    // No valid requesters holds the pointer at 4
    step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, -1, -1, -1, -1);
    step(1'b0, 8'h31, 1'b0, 1'b0, 8'h31, 4, 5, 0, -1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, -1, -1, -1, -1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, -1, -1, -1, -1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/anticipator_port_arb.md
Name: anticipator_port_arb

Overview:
Round-robin arbiter that shares the anticipator RAM's four combinational read ports between NREQ lookup requesters. The RAM holds 2-bit loop-prediction entries at 12-bit addresses. Each cycle the arbiter grants up to four requesters and drives their addresses onto RAM ports 0..3. It registers the returned data and delivers it, with the requester's tag, exactly one cycle later. It sits between the front-end lookup clients and the anticipator RAM.

Parameters:
NREQ, 8, number of requesters (2..16)
AW, 12, RAM address width
DW, 2, RAM data width
TAGW, 4, requester tag width, returned unchanged with the response

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  NREQ  lookup request per requester
req_addr  in  NREQ*AW  request address; requester i uses bits [i*AW +: AW]
req_tag  in  NREQ*TAGW  request tag, packed the same way
req_ready  out  NREQ  grant; the request is accepted when valid and ready are both high
stall  in  1  freeze: no grants this cycle
flush  in  1  kill: discard responses captured this cycle
rsp_valid  out  NREQ  response valid, one-cycle pulse per accepted request
rsp_data  out  NREQ*DW  registered RAM data per requester
rsp_tag  out  NREQ*TAGW  registered tag per requester
ram_addr0..ram_addr3  out  AW each  RAM read addresses, ports 0..3
ram_data0..ram_data3  in  DW each  RAM read data, combinational from ram_addrN

Behaviour:
- Single clock domain. Reset is synchronous, active-high.
- Reset values: rr_ptr=0, rsp_valid=0, rsp_data=0, rsp_tag=0.
- While rst is high, req_ready=0 and ram_addrN=0.
- Grant (combinational, within the cycle):
  - Scan requesters rr_ptr, rr_ptr+1, ..., wrapping mod NREQ.
  - The first four with req_valid=1 receive slots 0,1,2,3 in scan order.
  - Slot k drives ram_addrk with that requester's address.
  - Unused slots drive address 0.
- req_ready[i]=1 only if requester i is granted this cycle.
  - req_ready depends combinationally on req_valid, stall and rst.
  - Requesters must not make req_valid depend on req_ready.
- stall=1: every req_ready=0 and every ram_addrN=0. rr_ptr is held. Responses already registered still appear normally.
- Capture (clock edge), for each granted requester i:
  - rsp_data[i] <= data from its slot.
  - rsp_tag[i] <= req_tag[i].
  - rsp_valid[i] <= ~flush.
- Non-granted requesters: rsp_valid <= 0. rsp_data and rsp_tag hold their previous values.
- Latency: exactly 1 cycle from acceptance to rsp_valid. There is no response backpressure; requesters must sink responses.
- Pointer update:
  - If at least one grant: rr_ptr <= (index of last granted requester + 1) mod NREQ.
  - Otherwise rr_ptr holds.
  - This guarantees every valid requester is granted within ceil(NREQ/4) cycles.
- flush=1:
  - Grants still occur, so req_ready is unaffected and the requests count as consumed.
  - rsp_valid is 0 next cycle for all requesters.
  - rr_ptr updates normally.
- stall and flush together: no grants, and all rsp_valid are 0 next cycle.
- Fewer than four valid requesters: all are granted. Zero valid requesters: no grant, ptr held.
- Wrap-around: the scan crosses index NREQ-1 to index 0 seamlessly.
- Reset mid-operation: any response pending from the cycle before rst does not appear (rsp_valid=0). Arbitration restarts from requester 0.
- The same requester is never granted twice in one cycle.
- No RAM port carries two requesters.

Test Plan:
- Reset, then all 8 valid with addresses i → cycle 1: grant 0..3 on ports 0..3, ptr=4. Cycle 2: grant 4..7, ptr=0. Each rsp_valid pulses exactly one cycle after its grant.
- Only req 5 valid, address 12'h081, tag 4'hA, with the anticipator RAM attached → ready[5]=1, ram_addr0=12'h081. Next cycle rsp_valid[5]=1, rsp_data[5]=2'b11, rsp_tag[5]=4'hA.
- Only req 2 valid, address 12'h000 → rsp_data[2]=2'b00 next cycle; ram_addr1..3=0.
- ptr=6, requests 7, 0, 1, 3, 4 valid → grants 7 (port 0), 0 (port 1), 1 (port 2), 3 (port 3); 4 not ready. ptr becomes 4, and 4 is granted on port 0 next cycle.
- stall=1 for 3 cycles with all valid → req_ready=0 throughout, ptr unchanged, no rsp_valid. After release, arbitration resumes from the held ptr.
- flush=1 in the cycle requests 0..3 are granted → ptr advances to 4 but no rsp_valid next cycle. A repeat without flush delivers all four.
- rst asserted the cycle after a grant → rsp_valid stays 0 and the next grant starts at requester 0.
